// File: rtl/regfile_sb.sv
// regfile_sb: scoreboarded register file with two combinational read ports
// and two clocked write ports for the multi-cycle ARM datapath.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ra1/ra2 -> rd1/rd2  combinational reads; PC_IDX returns r15
//   busy1/busy2         busy bits of ra1/ra2 (PC_IDX never busy)
//   r15                 PC+8 value returned for PC_IDX reads
//   we3/wa3/wd3         result writeback port (wins on address conflict)
//   we4/wa4/wd4         base-register writeback port
//   rsv/rsv_addr        reserve request: marks rsv_addr busy
//   npend               registered count of busy registers
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the matching busy clear) onto the read ports.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int AW     = 4,
  parameter int PC_IDX = NREGS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic [WIDTH-1:0] r15,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic [AW:0]      npend
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [WIDTH-1:0] rf [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      pend_nxt;

  // Effective write strobes: PC is never written; port 4 loses a collision.
  logic commit3, commit4;
  assign commit3 = we3 && (wa3 != PC_A);
  assign commit4 = we4 && (wa4 != PC_A) && !(we3 && (wa3 == wa4));

  // Next busy vector: writes clear first, then a reserve sets, so a reserve
  // in the same cycle as a write to that register leaves it busy. A dropped
  // port-4 write shares its address with port 3, so its clear is implied.
  always_comb begin
    busy_nxt = busy;
    if (commit3) busy_nxt[wa3] = 1'b0;
    if (commit4) busy_nxt[wa4] = 1'b0;
    if (rsv && (rsv_addr != PC_A)) busy_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NREGS; i++) pend_nxt = pend_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      busy  <= '0;
      npend <= '0;
    end else begin
      if (commit3) rf[wa3] <= wd3;
      if (commit4) rf[wa4] <= wd4;
      busy  <= busy_nxt;
      npend <= pend_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit3_1, hit4_1, hit3_2, hit4_2;
  assign hit3_1 = we3 && (wa3 == ra1);
  assign hit4_1 = we4 && (wa4 == ra1);
  assign hit3_2 = we3 && (wa3 == ra2);
  assign hit4_2 = we4 && (wa4 == ra2);

  always_comb begin
    if (ra1 == PC_A) begin
      rd1   = r15;
      busy1 = 1'b0;
    end else if (hit3_1 || hit4_1) begin
      rd1   = hit3_1 ? wd3 : wd4;
      busy1 = rsv && (rsv_addr == ra1);
    end else begin
      rd1   = rf[ra1];
      busy1 = busy[ra1];
    end
    if (ra2 == PC_A) begin
      rd2   = r15;
      busy2 = 1'b0;
    end else if (hit3_2 || hit4_2) begin
      rd2   = hit3_2 ? wd3 : wd4;
      busy2 = rsv && (rsv_addr == ra2);
    end else begin
      rd2   = rf[ra2];
      busy2 = busy[ra2];
    end
  end
`else
  always_comb begin
    rd1   = (ra1 == PC_A) ? r15 : rf[ra1];
    busy1 = (ra1 == PC_A) ? 1'b0 : busy[ra1];
    rd2   = (ra2 == PC_A) ? r15 : rf[ra2];
    busy2 = (ra2 == PC_A) ? 1'b0 : busy[ra2];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed bench for regfile_sb with a
// reference model (plain arrays) and an expected-response queue.
//
// Handshake between driver and monitor: in every cycle where chk_valid is 1
// the driver has pushed exactly one expected response {rd1, rd2, busy1,
// busy2, npend}; the monitor pops one entry at negedge+2 and compares it
// with the DUT outputs.
module tb_regfile_sb;

  localparam int W = 32 + 32 + 1 + 1 + 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ra1 = '0, ra2 = '0, wa3 = '0, wa4 = '0, rsv_addr = '0;
  logic [31:0] rd1, rd2, r15 = '0, wd3 = '0, wd4 = '0;
  logic        busy1, busy2;
  logic        we3 = 1'b0, we4 = 1'b0, rsv = 1'b0;
  logic [4:0]  npend;

  regfile_sb dut (
    .clk(clk), .reset(reset),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .r15(r15),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .rsv(rsv), .rsv_addr(rsv_addr), .npend(npend)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: architectural contents and pending-producer flags
  logic [31:0] m_rf [16];
  bit          m_busy [16];
  logic [W-1:0] exp_q[$];
  logic        chk_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_rf[i] = '0;
      m_busy[i] = 1'b0;
    end
  end

  function automatic bit writes_to(input logic [3:0] a);
    return (we3 && wa3 == a) || (we4 && wa4 == a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return r15;
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 == a) return wd3;
    if (we4 && wa4 == a) return wd4;
`endif
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [3:0] a);
    if (a == 4'd15) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (writes_to(a)) return rsv && rsv_addr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [4:0] exp_pend();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return 5'(n);
  endfunction

  // Driver: apply one cycle of stimulus, record the expected response, then
  // advance the model to its post-edge state.
  task automatic step(input logic [3:0] a1, input logic [3:0] a2,
                      input logic w3, input logic [3:0] a3, input logic [31:0] d3,
                      input logic w4, input logic [3:0] a4, input logic [31:0] d4,
                      input logic rs, input logic [3:0] rsa,
                      input logic [31:0] pc, input logic rst);
    @(negedge clk);
    #1;
    ra1 = a1; ra2 = a2;
    we3 = w3; wa3 = a3; wd3 = d3;
    we4 = w4; wa4 = a4; wd4 = d4;
    rsv = rs; rsv_addr = rsa; r15 = pc; reset = rst;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_rf[i] = '0;
        m_busy[i] = 1'b0;
      end
    end
    exp_q.push_back({exp_rd(a1), exp_rd(a2), exp_busy(a1), exp_busy(a2), exp_pend()});
    chk_valid = 1'b1;
    if (!rst) begin
      // Port 4 first so port 3 overwrites it on a shared address.
      if (w4 && a4 != 4'd15) begin m_rf[a4] = d4; m_busy[a4] = 1'b0; end
      if (w3 && a3 != 4'd15) begin m_rf[a3] = d3; m_busy[a3] = 1'b0; end
      if (rs && rsa != 4'd15) m_busy[rsa] = 1'b1;
    end
  endtask

  task automatic idle_read(input logic [3:0] a1, input logic [3:0] a2, input logic [31:0] pc);
    step(a1, a2, 0, 0, 0, 0, 0, 0, 0, 0, pc, 0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (chk_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL queue_underflow got=empty exp=entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rd1", rd1, e[70:39]);
          check("rd2", rd2, e[38:7]);
          check("busy1", 32'(busy1), 32'(e[6]));
          check("busy2", 32'(busy2), 32'(e[5]));
          check("npend", 32'(npend), 32'(e[4:0]));
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0]  a1, a2, a3, a4, rsa;
    logic        w3, w4, rs, rst;

    // Reset state
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1);
    idle_read(0, 14, 32'h100);

    // Dual write, then read both back
    step(0, 0, 1, 2, 32'hAAAA_0000, 1, 5, 32'h0000_BBBB, 0, 0, 0, 0);
    idle_read(2, 5, 0);

    // Write collision: port 3 wins
    step(0, 0, 1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 0, 0);
    idle_read(7, 7, 0);

    // PC index: writes and reserves ignored, reads return r15
    step(15, 0, 1, 15, 32'hDEAD, 0, 0, 0, 0, 0, 32'h108, 0);
    idle_read(15, 15, 32'h108);
    step(15, 0, 0, 0, 0, 0, 0, 0, 1, 15, 32'h108, 0);
    idle_read(15, 0, 32'h108);

    // Scoreboard: reserve, reserve+write, then plain write clears
    step(4, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    idle_read(4, 0, 0);
    step(4, 0, 1, 4, 32'h44, 0, 0, 0, 1, 4, 0, 0);
    idle_read(4, 0, 0);
    step(4, 0, 0, 0, 0, 1, 4, 32'h4444, 0, 0, 0, 0);
    idle_read(4, 4, 0);
    // Re-reserving a busy register, and writing a non-busy one
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    step(6, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    step(6, 8, 1, 8, 32'h88, 0, 0, 0, 0, 0, 0, 0);
    idle_read(6, 8, 0);

    // Asynchronous reset mid-run with a live, busy register
    step(0, 0, 1, 3, 32'h55, 0, 0, 0, 1, 3, 0, 0);
    idle_read(3, 6, 0);
    step(3, 6, 1, 3, 32'h99, 1, 6, 32'h66, 1, 6, 0, 1);
    idle_read(3, 6, 0);

    // Same-cycle read of a register being written
    step(9, 9, 1, 9, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle_read(9, 0, 0);
    step(9, 10, 1, 9, 32'h5678, 1, 10, 32'hA0A0, 1, 9, 0, 0);
    idle_read(9, 10, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      a1  = 4'($urandom_range(0, 15));
      a2  = 4'($urandom_range(0, 15));
      a3  = 4'($urandom_range(0, 15));
      a4  = ($urandom_range(0, 3) == 0) ? a3 : 4'($urandom_range(0, 15));
      rsa = ($urandom_range(0, 3) == 0) ? a3 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) a1 = a3;
      w3  = 1'($urandom_range(0, 1));
      w4  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step(a1, a2, w3, a3, $urandom, w4, a4, $urandom, rs, rsa, $urandom, rst);
    end

    @(negedge clk);
    #1;
    chk_valid = 1'b0;
    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
